// File: rtl/multdiv_issue_controller_pkg.sv
// Shared constants, state encoding and status codes for the mult/div issue path.
package multdiv_issue_controller_pkg;

  localparam logic [4:0] OPCODE_ALU = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  localparam int unsigned MD_RSTATUS_REG = 30;

  localparam logic [31:0] STATUS_MULT = 32'd1;
  localparam logic [31:0] STATUS_DIV  = 32'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic [31:0] md_status_code(input logic is_div);
    return is_div ? STATUS_DIV : STATUS_MULT;
  endfunction

endpackage

// File: rtl/multdiv_issue_controller_md_decode.sv
// Combinational mult/div decode of the D/X instruction; shared with the hazard unit.
module md_decode
  import multdiv_issue_controller_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        is_mult,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic alu_class;
  logic unused_bits;

  // Opcode/aluop match and destination field extraction.
  always_comb begin
    alu_class = (instruction[31:27] == OPCODE_ALU);
    is_mult   = alu_class && (instruction[6:2] == ALUOP_MULT);
    is_div    = alu_class && (instruction[6:2] == ALUOP_DIV);
    rd        = instruction[26:22];
  end

  assign unused_bits = ^{instruction[21:7], instruction[1:0]};

endmodule

// File: rtl/multdiv_issue_controller.sv
// Issues mult/div start pulses, stalls the front end while the unit is busy,
// and presents a one-cycle result bundle to the X/M latch.
module multdiv_issue_controller
  import multdiv_issue_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned RSTATUS_REG    = MD_RSTATUS_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_instruction,
  input  logic        kill,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        xm_md_valid,
  output logic        xm_md_wren,
  output logic [4:0]  xm_md_rd,
  output logic [31:0] xm_md_result,
  output logic        xm_md_exception
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       STATUS_RD = 5'(RSTATUS_REG);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic [4:0]       op_rd;
  logic [4:0]       res_rd;
  logic [31:0]      res_val;
  logic             res_exc;
  logic             post_reset;

  logic       dec_mult;
  logic       dec_div;
  logic [4:0] dec_rd;
  logic       issue;

  md_decode u_md_decode (
    .instruction (dx_instruction),
    .is_mult     (dec_mult),
    .is_div      (dec_div),
    .rd          (dec_rd)
  );

  // Start condition; post_reset keeps outputs quiet in the cycle after reset.
  always_comb begin
    issue = (state == IDLE) && (dec_mult || dec_div) && !kill && !reset && !post_reset;
  end

  // Start pulses, stall and the gated result bundle.
  always_comb begin
    ctrl_mult       = issue && dec_mult;
    ctrl_div        = issue && dec_div;
    stall           = !reset && (issue || (state == BUSY));
    xm_md_valid     = !reset && (state == DONE);
    xm_md_rd        = xm_md_valid ? res_rd  : '0;
    xm_md_result    = xm_md_valid ? res_val : '0;
    xm_md_exception = xm_md_valid && res_exc;
    xm_md_wren      = xm_md_valid && (res_rd != '0);
  end

  // Issue/busy/done sequencing with timeout counter and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_div     <= 1'b0;
      op_rd      <= '0;
      res_rd     <= '0;
      res_val    <= '0;
      res_exc    <= 1'b0;
      post_reset <= 1'b1;
    end else begin
      post_reset <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            op_div <= dec_div;
            op_rd  <= dec_rd;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (kill) begin
            state <= IDLE;
          end else if (md_result_rdy || (cnt == CNT_LAST)) begin
            state <= DONE;
            // Unit exception and timeout share the status-register path.
            if (md_result_rdy && !md_exception) begin
              res_rd  <= op_rd;
              res_val <= md_result;
              res_exc <= 1'b0;
            end else begin
              res_rd  <= STATUS_RD;
              res_val <= md_status_code(op_div);
              res_exc <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
